// File: rtl/rotary_encoder_ctrl_if.sv
// Signal bundle between the encoder front end and the register/UI logic that consumes it.
interface rotary_encoder_ctrl_if #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned PB_W  = 16
);
   logic             enc_a;
   logic             enc_b;
   logic             pb_n;
   logic             clear;
   logic [CNT_W-1:0] enc_counter;
   logic             step_cw;
   logic             step_ccw;
   logic             quad_err;
   logic             pb_held;
   logic [PB_W-1:0]  pb_cnt;
   logic             pb_short;
   logic             pb_long;

   modport master (
      output enc_a, enc_b, pb_n, clear,
      input  enc_counter, step_cw, step_ccw, quad_err, pb_held, pb_cnt, pb_short, pb_long
   );

   modport slave (
      input  enc_a, enc_b, pb_n, clear,
      output enc_counter, step_cw, step_ccw, quad_err, pb_held, pb_cnt, pb_short, pb_long
   );
endinterface

// File: rtl/rotary_encoder_ctrl.sv
// Quadrature encoder + pushbutton front end: sync, debounce, x1/x4 decode, bounded count, press timing.
// Define ENC_ACCEL_EN to enable same-direction step acceleration.
module rotary_encoder_ctrl #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned CNT_MIN    = 0,
   parameter int unsigned CNT_MAX    = 255,
   parameter int unsigned CNT_RESET  = 128,
   parameter int unsigned WRAP       = 0,
   parameter int unsigned QUAD_MODE  = 0,
   parameter int unsigned DEB_CYCLES = 1000,
   parameter int unsigned PB_W       = 16,
   parameter int unsigned LONG_PRESS = 50000,
   parameter int unsigned ACCEL_WIN  = 200000,
   parameter int unsigned ACCEL_STEP = 4
) (
   input logic                  clk,
   input logic                  rstn,
   rotary_encoder_ctrl_if.slave bus
);

   localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
   localparam int unsigned ExtW  = ((CNT_W > 32) ? CNT_W : 32) + 2;
   localparam int unsigned Range = CNT_MAX - CNT_MIN + 1;
   localparam logic        LongIsOne = (LONG_PRESS == 1);

   if (DEB_CYCLES < 1 || CNT_MIN >= CNT_MAX || (CNT_MAX >> CNT_W) != 0 ||
       (LONG_PRESS >> PB_W) != 0 || ACCEL_STEP < 1 || ACCEL_WIN < 1) begin : g_bad_params
      $error("rotary_encoder_ctrl: illegal parameter combination");
   end

   // Bit order throughout: {A, B, pb}
   logic [2:0]      sync1_q, sync2_q, deb_q, deb_d;
   logic [DebW-1:0] deb_cnt_q [3];
   logic [DebW-1:0] deb_cnt_d [3];
   logic [1:0]      ab_prev_q;
   logic            pb_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            step_cw_q, step_ccw_q, quad_err_q;
   logic            pb_held_q, pb_short_q, pb_short_d, pb_long_q, pb_long_d;
   logic [PB_W-1:0] pb_cnt_q, pb_cnt_d;
   logic [1:0]      pos_diff;
   logic            fwd, rev, cw_ev, ccw_ev, err_ev;
   logic [ExtW-1:0] cnt_x, nxt_x, step_x;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         deb_d[i]     = deb_q[i];
         deb_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) deb_d[i] = sync2_q[i];
            else deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
         end
      end
   end

   // Position along the CW cycle 00 -> 10 -> 11 -> 01.
   function automatic logic [1:0] quad_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   quad_pos = 2'd0;
         2'b10:   quad_pos = 2'd1;
         2'b11:   quad_pos = 2'd2;
         default: quad_pos = 2'd3;
      endcase
   endfunction

   always_comb begin
      pos_diff = quad_pos(deb_q[2:1]) - quad_pos(ab_prev_q);
      fwd      = (pos_diff == 2'd1);
      rev      = (pos_diff == 2'd3);
      err_ev   = (pos_diff == 2'd2);
      if (QUAD_MODE != 0) begin
         cw_ev  = fwd;
         ccw_ev = rev;
      end else begin
         cw_ev  = fwd && (ab_prev_q == 2'b01) && (deb_q[2:1] == 2'b00);
         ccw_ev = rev && (ab_prev_q == 2'b10) && (deb_q[2:1] == 2'b00);
      end
   end

`ifdef ENC_ACCEL_EN
   localparam int unsigned AccW    = $clog2(ACCEL_WIN + 1);
   localparam int unsigned StepBig = (WRAP != 0) ? (ACCEL_STEP % Range) : ACCEL_STEP;

   logic [AccW-1:0] acc_tmr_q, acc_tmr_d;
   logic            last_cw_q, last_cw_d, last_vld_q, last_vld_d;

   always_comb begin
      acc_tmr_d  = (acc_tmr_q == AccW'(ACCEL_WIN)) ? acc_tmr_q : acc_tmr_q + AccW'(1);
      last_cw_d  = last_cw_q;
      last_vld_d = last_vld_q;
      step_x     = ExtW'(1);
      // No previous step exists right after reset, so the first step is never accelerated.
      if (last_vld_q && (last_cw_q == cw_ev) && (acc_tmr_q < AccW'(ACCEL_WIN))) begin
         step_x = ExtW'(StepBig);
      end
      if (cw_ev || ccw_ev) begin
         acc_tmr_d  = '0;
         last_cw_d  = cw_ev;
         last_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_tmr_q  <= '0;
         last_cw_q  <= 1'b0;
         last_vld_q <= 1'b0;
      end else begin
         acc_tmr_q  <= acc_tmr_d;
         last_cw_q  <= last_cw_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   always_comb step_x = ExtW'(1);
`endif

   always_comb begin
      cnt_x = ExtW'(cnt_q);
      nxt_x = cnt_x;
      if (cw_ev) begin
         nxt_x = cnt_x + step_x;
         if (nxt_x > ExtW'(CNT_MAX)) begin
            nxt_x = (WRAP != 0) ? nxt_x - ExtW'(Range) : ExtW'(CNT_MAX);
         end
      end else if (ccw_ev) begin
         if (cnt_x < ExtW'(CNT_MIN) + step_x) begin
            nxt_x = (WRAP != 0) ? cnt_x + ExtW'(Range) - step_x : ExtW'(CNT_MIN);
         end else begin
            nxt_x = cnt_x - step_x;
         end
      end
      cnt_d = bus.clear ? CNT_W'(CNT_RESET) : nxt_x[CNT_W-1:0];
   end

   always_comb begin
      pb_cnt_d   = pb_cnt_q;
      pb_short_d = 1'b0;
      pb_long_d  = 1'b0;
      if (pb_prev_q && !deb_q[0]) begin
         pb_cnt_d  = PB_W'(1);
         pb_long_d = LongIsOne;
      end else if (!pb_prev_q && !deb_q[0]) begin
         if (pb_cnt_q != '1) begin
            pb_cnt_d  = pb_cnt_q + PB_W'(1);
            pb_long_d = (pb_cnt_q == PB_W'(LONG_PRESS - 1));
         end
      end else if (!pb_prev_q && deb_q[0]) begin
         pb_short_d = (pb_cnt_q < PB_W'(LONG_PRESS));
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q    <= 3'b001;
         sync2_q    <= 3'b001;
         deb_q      <= 3'b001;
         for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
         ab_prev_q  <= 2'b00;
         pb_prev_q  <= 1'b1;
         cnt_q      <= CNT_W'(CNT_RESET);
         step_cw_q  <= 1'b0;
         step_ccw_q <= 1'b0;
         quad_err_q <= 1'b0;
         pb_held_q  <= 1'b0;
         pb_cnt_q   <= '0;
         pb_short_q <= 1'b0;
         pb_long_q  <= 1'b0;
      end else begin
         sync1_q    <= {bus.enc_a, bus.enc_b, bus.pb_n};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         ab_prev_q  <= deb_q[2:1];
         pb_prev_q  <= deb_q[0];
         cnt_q      <= cnt_d;
         step_cw_q  <= cw_ev;
         step_ccw_q <= ccw_ev;
         quad_err_q <= err_ev;
         pb_held_q  <= ~deb_q[0];
         pb_cnt_q   <= pb_cnt_d;
         pb_short_q <= pb_short_d;
         pb_long_q  <= pb_long_d;
      end
   end

   assign bus.enc_counter = cnt_q;
   assign bus.step_cw     = step_cw_q;
   assign bus.step_ccw    = step_ccw_q;
   assign bus.quad_err    = quad_err_q;
   assign bus.pb_held     = pb_held_q;
   assign bus.pb_cnt      = pb_cnt_q;
   assign bus.pb_short    = pb_short_q;
   assign bus.pb_long     = pb_long_q;

endmodule

// File: tb/tb_rotary_encoder_ctrl.sv
// Scoreboard bench: a saturating (dut0) and a wrapping (dut1) instance share one stimulus stream.
module tb_rotary_encoder_ctrl;

`ifdef ENC_ACCEL_EN
   localparam int unsigned AccWin = 12;
   localparam int unsigned Hold   = 16;
   localparam int          PreRst = 134;
`else
   localparam int unsigned AccWin = 200000;
   localparam int unsigned Hold   = 10;
   localparam int          PreRst = 129;
`endif
   localparam int KCw = 0, KCcw = 1, KErr = 2, KShort = 3, KLong = 4;

   typedef struct {
      int kind;
      int val;
   } evt_t;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       enc_a = 1'b0, enc_b = 1'b0, pb_n = 1'b1, clr = 1'b0;
   logic [1:0] ab_now = 2'b00;
   evt_t       q0[$];
   evt_t       q1[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   rotary_encoder_ctrl_if #(.CNT_W(8), .PB_W(16)) bus0 ();
   rotary_encoder_ctrl_if #(.CNT_W(8), .PB_W(16)) bus1 ();

   assign bus0.enc_a = enc_a;
   assign bus0.enc_b = enc_b;
   assign bus0.pb_n  = pb_n;
   assign bus0.clear = clr;
   assign bus1.enc_a = enc_a;
   assign bus1.enc_b = enc_b;
   assign bus1.pb_n  = pb_n;
   assign bus1.clear = clr;

   rotary_encoder_ctrl #(
      .CNT_W(8), .WRAP(0), .QUAD_MODE(1), .DEB_CYCLES(4), .LONG_PRESS(20), .ACCEL_WIN(AccWin)
   ) u_dut0 (
      .clk (clk),
      .rstn(rstn),
      .bus (bus0)
   );

   rotary_encoder_ctrl #(
      .CNT_W(8), .WRAP(1), .QUAD_MODE(1), .DEB_CYCLES(4), .LONG_PRESS(20), .ACCEL_WIN(AccWin)
   ) u_dut1 (
      .clk (clk),
      .rstn(rstn),
      .bus (bus1)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic exp2(input int kind, input int v0, input int v1);
      q0.push_back('{kind, v0});
      q1.push_back('{kind, v1});
   endtask

   task automatic mon(input int inst, input int kind, input int cnt, input int pbc);
      evt_t e;
      if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL dut%0d unexpected event: got kind %0d expected none", inst, kind);
         return;
      end
      if (inst == 0) e = q0.pop_front();
      else e = q1.pop_front();
      chk($sformatf("dut%0d event kind", inst), kind, e.kind);
      chk($sformatf("dut%0d event value", inst), (kind >= KShort) ? pbc : cnt, e.val);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (bus0.step_cw)  mon(0, KCw, bus0.enc_counter, bus0.pb_cnt);
         if (bus0.step_ccw) mon(0, KCcw, bus0.enc_counter, bus0.pb_cnt);
         if (bus0.quad_err) mon(0, KErr, bus0.enc_counter, bus0.pb_cnt);
         if (bus0.pb_short) mon(0, KShort, bus0.enc_counter, bus0.pb_cnt);
         if (bus0.pb_long)  mon(0, KLong, bus0.enc_counter, bus0.pb_cnt);
         if (bus1.step_cw)  mon(1, KCw, bus1.enc_counter, bus1.pb_cnt);
         if (bus1.step_ccw) mon(1, KCcw, bus1.enc_counter, bus1.pb_cnt);
         if (bus1.quad_err) mon(1, KErr, bus1.enc_counter, bus1.pb_cnt);
         if (bus1.pb_short) mon(1, KShort, bus1.enc_counter, bus1.pb_cnt);
         if (bus1.pb_long)  mon(1, KLong, bus1.enc_counter, bus1.pb_cnt);
      end
   end

   function automatic logic [1:0] cw_next(input logic [1:0] ab);
      case (ab)
         2'b00:   cw_next = 2'b10;
         2'b10:   cw_next = 2'b11;
         2'b11:   cw_next = 2'b01;
         default: cw_next = 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] ccw_next(input logic [1:0] ab);
      case (ab)
         2'b00:   ccw_next = 2'b01;
         2'b01:   ccw_next = 2'b11;
         2'b11:   ccw_next = 2'b10;
         default: ccw_next = 2'b00;
      endcase
   endfunction

   task automatic set_ab(input logic [1:0] ab);
      @(posedge clk);
      #1;
      {enc_a, enc_b} = ab;
      ab_now = ab;
   endtask

   task automatic cw(input int v0, input int v1);
      exp2(KCw, v0, v1);
      set_ab(cw_next(ab_now));
      repeat (Hold - 1) @(posedge clk);
   endtask

   task automatic ccw(input int v0, input int v1);
      exp2(KCcw, v0, v1);
      set_ab(ccw_next(ab_now));
      repeat (Hold - 1) @(posedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " enc_counter0"}, bus0.enc_counter, 128);
      chk({tag, " enc_counter1"}, bus1.enc_counter, 128);
      chk({tag, " pulses"}, {bus0.step_cw, bus0.step_ccw, bus0.quad_err, bus0.pb_short,
                             bus0.pb_long}, 0);
      chk({tag, " pb_held"}, bus0.pb_held, 0);
      chk({tag, " pb_cnt"}, bus0.pb_cnt, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(posedge clk);

      // First CW edge: counter must move exactly 7 cycles after the raw change.
      exp2(KCw, 129, 129);
      set_ab(2'b10);
      repeat (6) @(posedge clk);
      #1;
      chk("latency before", bus0.enc_counter, 128);
      @(posedge clk);
      #1;
      chk("latency at 7", bus0.enc_counter, 129);
      chk("latency step_cw", bus0.step_cw, 1);
      repeat (Hold - 8) @(posedge clk);
      cw(130, 130);
      cw(131, 131);
      cw(132, 132);
      chk("cw seq count", bus0.enc_counter, 132);

      for (int i = 0; i < 123; i++) cw(133 + i, 133 + i);
      chk("at max sat", bus0.enc_counter, 255);
      chk("at max wrap", bus1.enc_counter, 255);
      cw(255, 0);
      ccw(254, 255);
      chk("ccw sat", bus0.enc_counter, 254);
      chk("ccw wrap", bus1.enc_counter, 255);
      cw(255, 0);

      // Short glitch on A must be swallowed by the debouncer.
      @(posedge clk);
      #1;
      enc_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      enc_a = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("glitch count0", bus0.enc_counter, 255);
      chk("glitch count1", bus1.enc_counter, 0);

      exp2(KErr, 255, 0);
      set_ab(2'b11);
      repeat (Hold) @(posedge clk);
      #1;
      chk("err count0", bus0.enc_counter, 255);

      exp2(KShort, 10, 10);
      @(posedge clk);
      #1;
      pb_n = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("pb_held pressed", bus0.pb_held, 1);
      @(posedge clk);
      #1;
      pb_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("short pb_cnt0", bus0.pb_cnt, 10);
      chk("short pb_cnt1", bus1.pb_cnt, 10);
      chk("pb_held released", bus0.pb_held, 0);

      exp2(KLong, 20, 20);
      @(posedge clk);
      #1;
      pb_n = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      pb_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("long pb_cnt", bus0.pb_cnt, 30);

      // Clear lands in the same cycle as a CW step.
      exp2(KCw, 128, 128);
      set_ab(2'b01);
      repeat (6) @(posedge clk);
      #1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      chk("clear count0", bus0.enc_counter, 128);
      chk("clear count1", bus1.enc_counter, 128);
      repeat (Hold) @(posedge clk);

`ifdef ENC_ACCEL_EN
      repeat (20) @(posedge clk);
      exp2(KCw, 129, 129);
      set_ab(cw_next(ab_now));
      repeat (9) @(posedge clk);
      exp2(KCw, 133, 133);
      set_ab(cw_next(ab_now));
      repeat (Hold) @(posedge clk);
      #1;
      chk("accel count", bus0.enc_counter, 133);
`endif

      cw(PreRst, PreRst);
      @(posedge clk);
      #1;
      pb_n = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("pre-reset count", bus0.enc_counter, PreRst);
      chk("pre-reset pb_held", bus0.pb_held, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk_idle("async reset");
      pb_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("dut0 queue drained", q0.size(), 0);
      chk("dut1 queue drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
